// File: rtl/sobel_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen_if
// Description : Pixel stream in, 3x3 window plus status out, for
//               sobel_window_gen. The master drives pixels and the slave
//               (the window generator) returns the window.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_window_gen_if;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       win_valid;
  logic       frame_done;

  modport master (
    output pix_in, pix_valid,
    input  p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid,
    output p1, p2, p3, p4, p5, p6, p7, p8, p9, win_valid, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_gen
// Description : Builds a sliding 3x3 pixel window from a raster-order pixel
//               stream using two line buffers and a 3x3 shift register.
//               Flags complete in-frame windows and end-of-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic               clk,
  input  logic               rst,
  sobel_window_gen_if.slave  bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_COL_WIN  = CW'(2);
  localparam logic [RW-1:0] C_ROW_WIN  = RW'(2);

  // Position of the next pixel to accept
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Window registers; index 0 is p1 ... index 8 is p9 (row-major)
  logic [8:0][7:0] win_q, win_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  // Line buffers: lb1 holds the previous line, lb2 the line before it
  logic [7:0] lb1_q [IMG_WIDTH];
  logic [7:0] lb2_q [IMG_WIDTH];

  logic       accept;
  logic [7:0] lb1_rd;
  logic [7:0] lb2_rd;

  assign accept = bus.pix_valid;
  assign lb1_rd = lb1_q[col_q];
  assign lb2_rd = lb2_q[col_q];

  // Next-state: raster counters, window shift and status flags
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Shift each row one column left, newest column enters on the right
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb2_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_in;
      // Row gating also hides stale previous-frame buffer contents
      win_valid_d  = (row_q >= C_ROW_WIN) && (col_q >= C_COL_WIN);
      frame_done_d = (row_q == C_ROW_LAST) && (col_q == C_COL_LAST);
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer update: read-before-write, lb1 spills into lb2
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      lb1_q[col_q] <= bus.pix_in;
      lb2_q[col_q] <= lb1_rd;
    end
  end

  assign bus.p1         = win_q[0];
  assign bus.p2         = win_q[1];
  assign bus.p3         = win_q[2];
  assign bus.p4         = win_q[3];
  assign bus.p5         = win_q[4];
  assign bus.p6         = win_q[5];
  assign bus.p7         = win_q[6];
  assign bus.p8         = win_q[7];
  assign bus.p9         = win_q[8];
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_gen
// Description : Bench for sobel_window_gen. A 4x4 instance runs the directed
//               frames, a 64x64 instance runs one random frame. Expected
//               windows come from a stored image and plain 3x3 extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_gen_if ifs ();
  sobel_window_gen_if ifb ();

  sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  sobel_window_gen #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, per instance (0 = 4x4, 1 = 64x64)
  int          wid [2] = '{4, 64};
  int          hgt [2] = '{4, 64};
  int          mr  [2];
  int          mc  [2];
  logic [7:0]  img [2][64][64];
  bit          have_win [2];
  logic [71:0] last_win [2];
  int          wv_cnt [2];
  int          fd_cnt [2];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_outputs(input int s, output logic [71:0] w, output logic wv, output logic fd);
    if (s == 0) begin
      w  = {ifs.p1, ifs.p2, ifs.p3, ifs.p4, ifs.p5, ifs.p6, ifs.p7, ifs.p8, ifs.p9};
      wv = ifs.win_valid;
      fd = ifs.frame_done;
    end else begin
      w  = {ifb.p1, ifb.p2, ifb.p3, ifb.p4, ifb.p5, ifb.p6, ifb.p7, ifb.p8, ifb.p9};
      wv = ifb.win_valid;
      fd = ifb.frame_done;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mr[s] = 0;
      mc[s] = 0;
      have_win[s] = 1'b0;
    end
  endtask

  task automatic check_zero(input int s, input string tag);
    logic [71:0] w;
    logic        wv, fd;
    read_outputs(s, w, wv, fd);
    check(tag, {w, wv, fd}, '0);
  endtask

  // One clock of stimulus on instance s, followed by checks against the model
  task automatic drive(input int s, input bit v, input logic [7:0] px);
    logic [71:0] w, ew;
    logic        wv, fd;
    bit          exp_wv, exp_fd;
    int          r, c;
    if (s == 0) begin ifs.pix_valid = v; ifs.pix_in = px; end
    else        begin ifb.pix_valid = v; ifb.pix_in = px; end
    @(posedge clk);
    #1;
    if (s == 0) ifs.pix_valid = 1'b0; else ifb.pix_valid = 1'b0;
    read_outputs(s, w, wv, fd);
    r = mr[s];
    c = mc[s];
    exp_wv = v && (r >= 2) && (c >= 2);
    exp_fd = v && (r == hgt[s] - 1) && (c == wid[s] - 1);
    check("win_valid", {79'd0, wv}, {79'd0, exp_wv});
    check("frame_done", {79'd0, fd}, {79'd0, exp_fd});
    if (wv === 1'b1) wv_cnt[s]++;
    if (fd === 1'b1) fd_cnt[s]++;
    if (v) begin
      img[s][r][c] = px;
      check("p9_newest", {72'd0, w[7:0]}, {72'd0, px});
      if (exp_wv) begin
        ew = {img[s][r-2][c-2], img[s][r-2][c-1], img[s][r-2][c],
              img[s][r-1][c-2], img[s][r-1][c-1], img[s][r-1][c],
              img[s][r][c-2],   img[s][r][c-1],   img[s][r][c]};
        check("window", {8'd0, w}, {8'd0, ew});
        last_win[s] = ew;
        have_win[s] = 1'b1;
      end else begin
        have_win[s] = 1'b0;
      end
      if (c == wid[s] - 1) begin
        mc[s] = 0;
        mr[s] = (r == hgt[s] - 1) ? 0 : r + 1;
      end else begin
        mc[s] = c + 1;
      end
    end else if (have_win[s]) begin
      check("hold_in_gap", {8'd0, w}, {8'd0, last_win[s]});
    end
  endtask

  task automatic run_frame(input int s, input int base, input bit gaps, input bit rnd);
    for (int i = 0; i < wid[s] * hgt[s]; i++) begin
      drive(s, 1'b1, rnd ? 8'($urandom) : 8'(base + i));
      if (gaps && (i != wid[s] * hgt[s] - 1) && ((i == 10) || ($urandom_range(0, 1) == 1)))
        repeat (3) drive(s, 1'b0, 8'($urandom));
    end
  endtask

  task automatic check_counts(input int s, input int frames, input string tag);
    check({tag, "_win_count"}, 80'(wv_cnt[s]), 80'(frames * (wid[s] - 2) * (hgt[s] - 2)));
    check({tag, "_done_count"}, 80'(fd_cnt[s]), 80'(frames));
    wv_cnt[s] = 0;
    fd_cnt[s] = 0;
  endtask

  initial begin
    ifs.pix_valid = 1'b0; ifs.pix_in = '0;
    ifb.pix_valid = 1'b0; ifb.pix_in = '0;
    model_reset();
    wv_cnt = '{0, 0};
    fd_cnt = '{0, 0};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_small");
    check_zero(1, "reset_big");
    rst = 1'b0;

    // Back-to-back 4x4 frame, pixel 0 presented as reset deasserts
    run_frame(0, 0, 1'b0, 1'b0);
    check_counts(0, 1, "frame1");

    // Same frame with idle gaps
    run_frame(0, 0, 1'b1, 1'b0);
    check_counts(0, 1, "gaps");

    // Two frames back-to-back, second frame 100..115
    run_frame(0, 0, 1'b0, 1'b0);
    run_frame(0, 100, 1'b0, 1'b0);
    check_counts(0, 2, "two_frames");

    // Reset mid-frame, then a fresh frame
    for (int i = 0; i < 8; i++) drive(0, 1'b1, 8'(i));
    #3 rst = 1'b1;
    #1;
    check_zero(0, "async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "held_reset");
    model_reset();
    wv_cnt[0] = 0;
    fd_cnt[0] = 0;
    rst = 1'b0;
    run_frame(0, 0, 1'b0, 1'b0);
    check_counts(0, 1, "after_reset");

    // Random 64x64 frame on the default-size instance
    run_frame(1, 0, 1'b0, 1'b1);
    check_counts(1, 1, "big_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
